demux8_slot_sequencer: RTL and testbench
========================================

Name: demux8_slot_sequencer

Overview:
- Upstream driver for the 1-to-8 demux. It accepts one 8-bit frame per handshake, one bit per output channel.
- Each enabled channel gets a time slot in turn. During its slot the block drives the 3-bit select (a = MSB, b, c = LSB) and the serial data bit d.
- Disabled channels are skipped. A programmable idle gap separates frames.
- All demux-facing outputs are registered, so the combinational demux sees glitch-free selects.

Parameters:
- HOLD, 1, cycles each slot is held; legal range 1..15.
- GAP_CYCLES, 1, idle cycles after the last slot of a frame before the next frame is accepted; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  8  frame; bit i is the value for channel i.
- in_valid  input  1  frame present.
- in_ready  output  1  block can accept a frame.
- ch_en  input  8  channel enable mask; sampled together with in_data on accept.
- a  output  1  select bit 2 (MSB) to demux.
- b  output  1  select bit 1 to demux.
- c  output  1  select bit 0 (LSB) to demux.
- d  output  1  serial data to demux.
- busy  output  1  high in SLOT or GAP.
- frame_done  output  1  one-cycle pulse when a frame finishes.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), so it takes effect only on a rising clk edge.
- Reset values: a, b, c, d, busy, frame_done and in_ready are all 0. State is IDLE, and the internal data, mask, slot and counters are cleared.
- Reset mid-operation: reset aborts any frame in progress with no frame_done. in_ready rises on the first edge after rst deasserts.
- FSM states: IDLE, SLOT, GAP.
- IDLE:
  - in_ready = 1, d = 0, {a,b,c} = 0.
  - Accept occurs when in_valid & in_ready on edge k; in_data and ch_en are latched.
  - If the latched ch_en == 0: frame_done pulses on edge k+1 and the state stays IDLE. No slots run and no gap follows.
  - Otherwise, on edge k+1: state becomes SLOT, slot = lowest set bit of ch_en, {a,b,c} = slot, d = in_data[slot], busy = 1, in_ready = 0.
  - Latency from accept to first slot output is 1 cycle.
- SLOT:
  - Outputs hold for exactly HOLD cycles.
  - Then slot advances to the next higher set bit of the latched mask. Scanning is ascending only, with no wrap within a frame.
  - Slot index arithmetic is 3-bit. The highest enabled index is the last slot. Channel 7 enabled must not wrap to 0.
  - After the last slot's HOLD cycles:
    - frame_done = 1 for one cycle, d = 0, {a,b,c} = 0.
    - If GAP_CYCLES > 0, go to GAP; otherwise go to IDLE with in_ready = 1 on that same edge.
- GAP:
  - Lasts GAP_CYCLES cycles with busy = 1, in_ready = 0, d = 0.
  - Then go to IDLE.
- in_valid outside IDLE: in_data is ignored (in_ready = 0). The upstream source must hold in_valid and in_data until the handshake completes.
- Cycle count: a frame with N enabled channels occupies N*HOLD cycles of SLOT, plus GAP_CYCLES, plus 1 IDLE cycle for acceptance.
- Mask changes: ch_en changes after accept have no effect on the current frame.

Decomposition:
- Shared package:
  - state enum {IDLE, SLOT, GAP}.
  - constants NCH = 8, SEL_W = 3.
  - HOLD and GAP counter width = 4.
- Sub-module: priority_next_slot, which is combinational. It takes an 8-bit mask and a 3-bit current index (plus a "first" flag) and returns the next set index above the current one, or the lowest set index when "first" is asserted, along with a "none" flag.
  - Used both for first-slot selection and for advancing.

Test Plan:
- Default params (HOLD=1, GAP_CYCLES=1), full mask. in_data=8'hA5, ch_en=8'hFF:
  - {a,b,c} steps 0..7 on consecutive cycles.
  - d sequence 1,0,1,0,0,1,0,1.
  - frame_done pulses after slot 7, one gap cycle follows, then in_ready = 1.
- Sparse mask. in_data=8'hFF, ch_en=8'b1000_0010:
  - Exactly two slots, sel=1 then sel=7, d=1 in both.
  - No wrap to sel=0 after 7; frame_done after sel=7.
- Zero mask. ch_en=8'h00:
  - No SLOT cycles.
  - frame_done pulses 1 cycle after accept; in_ready stays 1.
- HOLD=3, GAP_CYCLES=0, ch_en=8'h03, in_data=8'h02:
  - sel=0 with d=0 for 3 cycles, then sel=1 with d=1 for 3 cycles.
  - in_ready = 1 on the cycle frame_done is high.
  - A back-to-back frame is accepted on that cycle.
- Backpressure. Assert in_valid with 8'h0F during the SLOT of the previous frame:
  - Not accepted until IDLE.
  - Second frame's data emerges intact.
- Reset during slot 4 of a full-mask frame:
  - Next cycle all outputs are 0 and there is no frame_done.
  - in_ready = 1 the cycle after rst is released.

Source files
------------

// File: rtl/demux8_slot_sequencer_pkg.sv
// Shared types and constants for the demux8 slot sequencer.
package demux8_slot_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;
endpackage

// File: rtl/demux8_slot_sequencer_priority_next_slot.sv
// Finds the next enabled channel above cur, or the lowest enabled channel
// when first is set. Scanning never wraps, so cur = 7 always yields none.
module priority_next_slot
    import demux8_slot_sequencer_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             first,
    output logic [SEL_W-1:0] nxt,
    output logic             none
);
    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt  = SEL_W'(i);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/demux8_slot_sequencer.sv
// Upstream driver for a 1-to-8 demux: serialises one 8-bit frame over the
// enabled channels, one slot per channel, with registered select/data.
module demux8_slot_sequencer
    import demux8_slot_sequencer_pkg::*;
#(
    parameter int HOLD       = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] ch_en,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_t             state_q, state_n;
    logic [SEL_W-1:0]   slot_q, slot_n;
    logic [NCH-1:0]     data_q, data_n;
    logic [NCH-1:0]     mask_q, mask_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic               d_n, fd_n;

    // In IDLE the finder looks at the live mask so the first slot can be
    // registered on the accept edge; afterwards it walks the latched mask.
    logic               pn_first, pn_none;
    logic [NCH-1:0]     pn_mask;
    logic [SEL_W-1:0]   pn_idx;

    assign pn_first = (state_q == IDLE);
    assign pn_mask  = pn_first ? ch_en : mask_q;

    priority_next_slot u_next (
        .mask  (pn_mask),
        .cur   (slot_q),
        .first (pn_first),
        .nxt   (pn_idx),
        .none  (pn_none)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        slot_n  = slot_q;
        data_n  = data_q;
        mask_n  = mask_q;
        cnt_n   = cnt_q;
        sel_n   = {a, b, c};
        d_n     = d;
        fd_n    = 1'b0;
        case (state_q)
            IDLE: begin
                sel_n = '0;
                d_n   = 1'b0;
                if (in_valid && in_ready) begin
                    data_n = in_data;
                    mask_n = ch_en;
                    if (pn_none) begin
                        fd_n = 1'b1;
                    end else begin
                        state_n = SLOT;
                        slot_n  = pn_idx;
                        sel_n   = pn_idx;
                        d_n     = in_data[pn_idx];
                        cnt_n   = HOLD_LD;
                    end
                end
            end
            SLOT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (pn_none) begin
                    fd_n  = 1'b1;
                    sel_n = '0;
                    d_n   = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                        cnt_n   = GAP_LD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    slot_n = pn_idx;
                    sel_n  = pn_idx;
                    d_n    = data_q[pn_idx];
                    cnt_n  = HOLD_LD;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_n = IDLE;
                else             cnt_n   = cnt_q - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered demux-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            {a, b, c}  <= '0;
            d          <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            state_q    <= state_n;
            slot_q     <= slot_n;
            data_q     <= data_n;
            mask_q     <= mask_n;
            cnt_q      <= cnt_n;
            {a, b, c}  <= sel_n;
            d          <= d_n;
            busy       <= (state_n != IDLE);
            frame_done <= fd_n;
            in_ready   <= (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_demux8_slot_sequencer.sv
// Directed bench for demux8_slot_sequencer: a default-parameter instance and
// a HOLD=3 / GAP_CYCLES=0 instance share clock and reset.
module tb_demux8_slot_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] in_data = '0, ch_en = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, a, b, c, d, busy, frame_done;

    logic [7:0] in_data_h = '0, ch_en_h = '0;
    logic       in_valid_h = 1'b0;
    logic       in_ready_h, a_h, b_h, c_h, d_h, busy_h, frame_done_h;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    demux8_slot_sequencer u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ch_en(ch_en), .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .frame_done(frame_done)
    );

    demux8_slot_sequencer #(.HOLD(3), .GAP_CYCLES(0)) u_dut_h (
        .clk(clk), .rst(rst), .in_data(in_data_h), .in_valid(in_valid_h),
        .in_ready(in_ready_h), .ch_en(ch_en_h), .a(a_h), .b(b_h), .c(c_h), .d(d_h),
        .busy(busy_h), .frame_done(frame_done_h)
    );

    // Observation vectors: {sel[2:0], d, busy, in_ready, frame_done}
    function automatic logic [6:0] o1();
        return {a, b, c, d, busy, in_ready, frame_done};
    endfunction

    function automatic logic [6:0] o2();
        return {a_h, b_h, c_h, d_h, busy_h, in_ready_h, frame_done_h};
    endfunction

    function automatic logic [6:0] ev(input logic [2:0] s, input logic dd,
                                      input logic bz, input logic rd, input logic fd);
        return {s, dd, bz, rd, fd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        rst = 1'b1;
        step();
        e = 7'b0;
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL reset_vals: got %b want %b", o1(), e); end
        rst = 1'b0;
        step();
        e = ev(3'd0, 0, 0, 1, 0);
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL reset_release: got %b want %b", o1(), e); end
        tests++;
        if (o2() !== e) begin failed++; $display("FAIL reset_release_h: got %b want %b", o2(), e); end
    endtask

    task automatic test_full();
        logic [7:0] exp_d;
        logic [6:0] e;
        exp_d = 8'b1010_0101;
        in_data = 8'hA5; ch_en = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            e = ev(3'(i), exp_d[i], 1, 0, 0);
            tests++;
            if (o1() !== e) begin failed++; $display("FAIL full_slot%0d: got %b want %b", i, o1(), e); end
        end
        step();
        e = ev(3'd0, 0, 1, 0, 1);
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL full_done: got %b want %b", o1(), e); end
        step();
        e = ev(3'd0, 0, 0, 1, 0);
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL full_idle: got %b want %b", o1(), e); end
    endtask

    task automatic test_sparse();
        logic [6:0] exp_seq [4];
        exp_seq[0] = ev(3'd1, 1, 1, 0, 0);
        exp_seq[1] = ev(3'd7, 1, 1, 0, 0);
        exp_seq[2] = ev(3'd0, 0, 1, 0, 1);
        exp_seq[3] = ev(3'd0, 0, 0, 1, 0);
        in_data = 8'hFF; ch_en = 8'b1000_0010; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            tests++;
            if (o1() !== exp_seq[i]) begin
                failed++; $display("FAIL sparse_c%0d: got %b want %b", i, o1(), exp_seq[i]);
            end
        end
    endtask

    task automatic test_zero();
        logic [6:0] e;
        in_data = 8'hFF; ch_en = 8'h00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        e = ev(3'd0, 0, 0, 1, 1);
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL zero_done: got %b want %b", o1(), e); end
        step();
        e = ev(3'd0, 0, 0, 1, 0);
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL zero_after: got %b want %b", o1(), e); end
    endtask

    // Second frame is presented during the first frame's slots; the mask
    // input also changes mid-frame and must not disturb the first frame.
    task automatic test_backpressure();
        logic [6:0] exp_seq [10];
        exp_seq[0] = ev(3'd0, 1, 1, 0, 0);
        exp_seq[1] = ev(3'd1, 0, 1, 0, 0);
        exp_seq[2] = ev(3'd0, 0, 1, 0, 1);
        exp_seq[3] = ev(3'd0, 0, 0, 1, 0);
        exp_seq[4] = ev(3'd2, 1, 1, 0, 0);
        exp_seq[5] = ev(3'd3, 1, 1, 0, 0);
        exp_seq[6] = ev(3'd4, 0, 1, 0, 0);
        exp_seq[7] = ev(3'd5, 0, 1, 0, 0);
        exp_seq[8] = ev(3'd0, 0, 1, 0, 1);
        exp_seq[9] = ev(3'd0, 0, 0, 1, 0);
        in_data = 8'h01; ch_en = 8'h03; in_valid = 1'b1;
        step();
        in_data = 8'h0F; ch_en = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            if (i == 4) in_valid = 1'b0;
            tests++;
            if (o1() !== exp_seq[i]) begin
                failed++; $display("FAIL bp_c%0d: got %b want %b", i, o1(), exp_seq[i]);
            end
        end
    endtask

    task automatic test_hold3();
        logic [6:0] e;
        in_data_h = 8'h02; ch_en_h = 8'h03; in_valid_h = 1'b1;
        step();
        in_valid_h = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            if (i < 3) e = ev(3'd0, 0, 1, 0, 0);
            else       e = ev(3'd1, 1, 1, 0, 0);
            if (i == 5) begin in_data_h = 8'h80; ch_en_h = 8'h80; in_valid_h = 1'b1; end
            tests++;
            if (o2() !== e) begin failed++; $display("FAIL hold3_c%0d: got %b want %b", i, o2(), e); end
        end
        step();
        e = ev(3'd0, 0, 0, 1, 1);
        tests++;
        if (o2() !== e) begin failed++; $display("FAIL hold3_done: got %b want %b", o2(), e); end
        step();
        in_valid_h = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            e = ev(3'd7, 1, 1, 0, 0);
            tests++;
            if (o2() !== e) begin failed++; $display("FAIL b2b_c%0d: got %b want %b", i, o2(), e); end
        end
        step();
        e = ev(3'd0, 0, 0, 1, 1);
        tests++;
        if (o2() !== e) begin failed++; $display("FAIL b2b_done: got %b want %b", o2(), e); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] e;
        in_data = 8'hA5; ch_en = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        e = ev(3'd4, 0, 1, 0, 0);
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL rmid_slot4: got %b want %b", o1(), e); end
        rst = 1'b1;
        step();
        e = 7'b0;
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL rmid_reset: got %b want %b", o1(), e); end
        rst = 1'b0;
        step();
        e = ev(3'd0, 0, 0, 1, 0);
        tests++;
        if (o1() !== e) begin failed++; $display("FAIL rmid_release: got %b want %b", o1(), e); end
    endtask

    initial begin
        test_reset();
        test_full();
        test_sparse();
        test_zero();
        test_backpressure();
        test_hold3();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
